// File: rtl/rt_pkg.sv
// Shared types and constants for the random target selector.
package rt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StWaitHit,
    StResult
  } rt_state_e;

  // Width of a channel index; never less than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Right-shifting Galois feedback masks giving a maximal-length sequence.
  function automatic logic [15:0] lfsr_taps(input int unsigned w);
    logic [15:0] taps;
    case (w)
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0E08;
      13:      taps = 16'h1C80;
      14:      taps = 16'h3802;
      15:      taps = 16'h6000;
      16:      taps = 16'hB400;
      default: taps = 16'h00B8;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running maximal-length Galois LFSR; advances every clock.
module lfsr_gen
  import rt_pkg::*;
#(
  parameter int unsigned          LFSR_W = 8,
  parameter logic [LFSR_W-1:0]    SEED   = 'hA5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  localparam logic [15:0]       TapsAll = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] Taps    = TapsAll[LFSR_W-1:0];

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q >> 1;
    if (q_q[0]) q_d = (q_q >> 1) ^ Taps;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/random_target_sel.sv
// Picks a random target channel on start, then reports whether the first new press hit it,
// missed it, or never came before the timeout.
module random_target_sel
  import rt_pkg::*;
#(
  parameter int unsigned       N_CH   = 8,
  parameter int unsigned       LFSR_W = 8,
  parameter logic [LFSR_W-1:0] SEED   = 'hA5,
  parameter int unsigned       TMO_W  = 24,
  localparam int unsigned      SEL_W  = sel_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_CH-1:0]  in_ch,
  input  logic [TMO_W-1:0] timeout_cyc,
  output logic [SEL_W-1:0] target,
  output logic             busy,
  output logic             hit,
  output logic             miss,
  output logic             timed_out,
  output logic             done
);

  localparam logic [SEL_W:0] NChW = (SEL_W + 1)'(N_CH);

  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign lfsr_unused = ^lfsr;

  rt_state_e         state_q, state_d;
  logic [SEL_W-1:0]  target_q, target_d;
  logic [N_CH-1:0]   in_prev_q;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic              tmo_q, tmo_d;
  logic              done_q, done_d;

  // Fold out-of-range LFSR values back into 0..N_CH-1.
  logic [SEL_W:0]   raw_ext, red_ext;
  logic [SEL_W-1:0] sel_new;
  assign raw_ext = {1'b0, lfsr[SEL_W-1:0]};
  assign red_ext = (raw_ext >= NChW) ? (raw_ext - NChW) : raw_ext;
  assign sel_new = red_ext[SEL_W-1:0];

  logic [N_CH-1:0]  rise, tgt_mask;
  logic             rise_tgt, rise_other;
  logic [TMO_W-1:0] cnt_inc;
  logic             tmo_reached;

  assign rise       = in_ch & ~in_prev_q;
  assign tgt_mask   = {{(N_CH - 1){1'b0}}, 1'b1} << target_q;
  assign rise_tgt   = |(rise & tgt_mask);
  assign rise_other = |(rise & ~tgt_mask);

  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
  assign tmo_reached = (timeout_cyc != '0) && (cnt_inc >= timeout_cyc);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    tmo_d    = tmo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle, StResult: begin
        if (start) begin
          target_d = sel_new;
          hit_d    = 1'b0;
          miss_d   = 1'b0;
          tmo_d    = 1'b0;
          state_d  = StArm;
        end
      end
      StArm: begin
        if (in_ch == '0) begin
          cnt_d   = '0;
          state_d = StWaitHit;
        end
      end
      StWaitHit: begin
        // A stray press outranks a target press, and any press outranks the timeout.
        if (rise_other) begin
          miss_d  = 1'b1;
          done_d  = 1'b1;
          state_d = StResult;
        end else if (rise_tgt) begin
          hit_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StResult;
        end else if (timeout_cyc != '0) begin
          cnt_d = cnt_inc;
          if (tmo_reached) begin
            tmo_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StResult;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      target_q  <= '0;
      in_prev_q <= '0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      tmo_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      in_prev_q <= in_ch;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
    end
  end

  assign target    = target_q;
  assign busy      = (state_q == StArm) || (state_q == StWaitHit);
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign timed_out = tmo_q;
  assign done      = done_q;

endmodule

// File: tb/tb_random_target_sel.sv
// Directed bench for random_target_sel: an 8-channel and a 5-channel instance.
module tb_random_target_sel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start5 = 1'b0;
  logic [7:0]  in_ch = '0;
  logic [4:0]  in5 = '0;
  logic [23:0] timeout_cyc = '0;

  logic [2:0]  target, target5;
  logic        busy, hit, miss, timed_out, done;
  logic        busy5, hit5, miss5, tmo5, done5;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  m_lfsr;

  always #5 clk = ~clk;

  random_target_sel #(.N_CH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_ch       (in_ch),
    .timeout_cyc (timeout_cyc),
    .target      (target),
    .busy        (busy),
    .hit         (hit),
    .miss        (miss),
    .timed_out   (timed_out),
    .done        (done)
  );

  random_target_sel #(.N_CH(5)) dut5 (
    .clk         (clk),
    .rst         (rst),
    .start       (start5),
    .in_ch       (in5),
    .timeout_cyc (24'd0),
    .target      (target5),
    .busy        (busy5),
    .hit         (hit5),
    .miss        (miss5),
    .timed_out   (tmo5),
    .done        (done5)
  );

  // Reference x^8+x^6+x^5+x^4+1 Galois sequence from seed A5.
  always @(posedge clk or posedge rst) begin
    if (rst)            m_lfsr <= 8'hA5;
    else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 8'hB8;
    else                m_lfsr <= m_lfsr >> 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until the LFSR low bits equal t, then pulse start so that t is latched.
  task automatic pick(input logic [2:0] t);
    int k = 0;
    while (m_lfsr[2:0] != t && k < 600) begin
      tick();
      k++;
    end
    check_eq("pick_bound", (k < 600), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [2:0] red5(input logic [7:0] v);
    logic [2:0] r;
    r = v[2:0];
    return (r >= 3'd5) ? r - 3'd5 : r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ndone;
    logic [2:0] exp5;
    #12 rst = 1'b0;
    tick();
    check_eq("rst_target", target, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_hit", hit, 0);
    check_eq("rst_miss", miss, 0);
    check_eq("rst_tmo", timed_out, 0);
    check_eq("rst_done", done, 0);

    // Clean hit on target 5.
    pick(3'd5);
    check_eq("hit_target", target, 5);
    check_eq("hit_busy_arm", busy, 1);
    tick();
    in_ch = 8'h20;
    tick();
    check_eq("hit_flag", hit, 1);
    check_eq("hit_miss", miss, 0);
    check_eq("hit_done", done, 1);
    check_eq("hit_busy", busy, 0);
    tick();
    check_eq("hit_done_once", done, 0);
    check_eq("hit_hold", hit, 1);
    in_ch = 8'h00;
    tick();

    // Miss on target 2, later target press ignored.
    pick(3'd2);
    check_eq("miss_hit_cleared", hit, 0);
    tick();
    in_ch = 8'h40;
    tick();
    check_eq("miss_flag", miss, 1);
    check_eq("miss_done", done, 1);
    in_ch = 8'h44;
    tick();
    check_eq("miss_late_hit", hit, 0);
    check_eq("miss_hold", miss, 1);
    check_eq("miss_late_done", done, 0);
    in_ch = 8'h00;
    tick();

    // Simultaneous target and stray edge: miss wins; start ignored while waiting.
    pick(3'd3);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("ign_start_busy", busy, 1);
    check_eq("ign_start_target", target, 3);
    in_ch = 8'h09;
    tick();
    check_eq("both_miss", miss, 1);
    check_eq("both_hit", hit, 0);
    in_ch = 8'h00;
    tick();

    // Timeout of 10 cycles after entering WAIT_HIT.
    timeout_cyc = 24'd10;
    pick(3'd0);
    tick();
    ndone = 0;
    for (int i = 1; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    check_eq("tmo_early_done", ndone, 0);
    tick();
    check_eq("tmo_done", done, 1);
    check_eq("tmo_flag", timed_out, 1);
    check_eq("tmo_hit", hit, 0);
    check_eq("tmo_miss", miss, 0);
    tick();
    check_eq("tmo_done_once", done, 0);
    check_eq("tmo_hold", timed_out, 1);

    // Press landing on the timeout cycle wins.
    timeout_cyc = 24'd3;
    pick(3'd6);
    check_eq("tmo_cleared", timed_out, 0);
    tick();
    tick();
    tick();
    in_ch = 8'h40;
    tick();
    check_eq("edge_vs_tmo_hit", hit, 1);
    check_eq("edge_vs_tmo_tmo", timed_out, 0);
    in_ch = 8'h00;
    tick();

    // Timeout disabled.
    timeout_cyc = 24'd0;
    pick(3'd7);
    tick();
    ndone = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (done) ndone++;
    end
    check_eq("notmo_done", ndone, 0);
    check_eq("notmo_busy", busy, 1);
    in_ch = 8'h01;
    tick();
    check_eq("notmo_miss", miss, 1);
    in_ch = 8'h00;
    tick();

    // Input held at start keeps ARM; the later press is a fresh edge.
    in_ch = 8'h02;
    pick(3'd1);
    for (int i = 0; i < 5; i++) tick();
    check_eq("arm_hold_busy", busy, 1);
    check_eq("arm_hold_hit", hit, 0);
    in_ch = 8'h00;
    tick();
    in_ch = 8'h02;
    tick();
    check_eq("arm_new_edge_hit", hit, 1);
    in_ch = 8'h00;
    tick();

    // Reset mid-WAIT_HIT aborts silently.
    pick(3'd4);
    tick();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_target", target, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_flags", {hit, miss, timed_out, done}, 0);
    #3 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) ndone++;
    end
    check_eq("mid_rst_no_done", ndone, 0);
    check_eq("mid_rst_idle", busy, 0);

    // 1000 rounds on the 5-channel instance.
    for (int r = 0; r < 1000; r++) begin
      start5 = 1'b1;
      exp5 = red5(m_lfsr);
      tick();
      start5 = 1'b0;
      check_eq("n5_target", target5, exp5);
      check_eq("n5_range", (target5 < 3'd5), 1);
      tick();
      in5 = 5'b00001;
      tick();
      in5 = 5'b00000;
      tick();
    end
    check_eq("n5_done_state", busy5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/random_target_sel.md
RANDOM_TARGET_SEL -- requirements
Module: random_target_sel

Interface
REQ-001 Parameter N_CH, default 8: number of candidate stop inputs; legal range 2..16.
REQ-002 Parameter LFSR_W, default 8: LFSR width; legal range 4..16; LFSR_W SHALL be >= SEL_W.
REQ-003 Parameter SEED, default 8'hA5: LFSR reset value; SHALL be nonzero.
REQ-004 Parameter TMO_W, default 24: timeout counter width.
REQ-005 Derived constant SEL_W = max(1, clog2(N_CH)).
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to pick a new target.
REQ-009 in_ch  in  N_CH  stop inputs (switches/buttons); already synchronised and debounced; active-high.
REQ-010 timeout_cyc  in  TMO_W  cycles allowed in WAIT_HIT; 0 disables timeout.
REQ-011 target  out  SEL_W  latched target channel index.
REQ-012 busy  out  1  high in ARM and WAIT_HIT.
REQ-013 hit  out  1  result flag: correct input pressed.
REQ-014 miss  out  1  result flag: wrong input pressed.
REQ-015 timed_out  out  1  result flag: no press before timeout.
REQ-016 done  out  1  one-cycle pulse when a result is set.

Function
REQ-017 The LFSR SHALL be a maximal-length Galois LFSR that advances every cycle, regardless of state.
REQ-018 States SHALL be IDLE, ARM, WAIT_HIT, RESULT.
REQ-019 In IDLE or RESULT, start=1 SHALL latch target = lfsr[SEL_W-1:0], reduced by N_CH if >= N_CH, clear hit/miss/timed_out and enter ARM on the next cycle.
REQ-020 start SHALL be ignored in ARM and WAIT_HIT.
REQ-021 ARM SHALL remain until in_ch is all zeros for one cycle, then enter WAIT_HIT with the timeout counter cleared.
REQ-022 A rising edge SHALL be defined as in_ch & ~in_prev, where in_prev is in_ch registered every cycle.
REQ-023 In WAIT_HIT, a rising edge on any non-target bit SHALL set miss, pulse done and enter RESULT.
REQ-024 In WAIT_HIT, a rising edge on the target bit only SHALL set hit, pulse done and enter RESULT.
REQ-025 When target and non-target edges occur in the same cycle, miss SHALL win.
REQ-026 In WAIT_HIT with timeout_cyc != 0, the counter SHALL increment each cycle without an edge; on reaching timeout_cyc it SHALL set timed_out, pulse done and enter RESULT.
REQ-027 An edge in the same cycle that the counter reaches timeout_cyc SHALL take priority over the timeout.
REQ-028 The counter SHALL saturate and never wrap.
REQ-029 Result flags and target SHALL hold in RESULT until the next accepted start; exactly one result flag SHALL be high in RESULT.
REQ-030 done SHALL be registered and assert in the cycle the FSM enters RESULT.

Reset
REQ-031 rst SHALL force: state IDLE, lfsr = SEED, in_prev = 0, counter = 0, target = 0, hit/miss/timed_out/done/busy = 0.
REQ-032 rst asserted mid-round SHALL abort the round with no done pulse.

Structure
REQ-033 The state encoding typedef and the SEL_W derivation function SHALL live in the shared package rt_pkg.
REQ-034 The LFSR SHALL be a separate sub-module, lfsr_gen (parameters LFSR_W, SEED; ports clk, rst, q).

Verification
REQ-035 N_CH=8, LFSR forced so target=5; press in_ch[5] with no other press -> hit=1, done pulses once, busy falls.
REQ-036 target=2; press in_ch[6] -> miss=1; next cycle press in_ch[2] -> no change until the next start.
REQ-037 target=3; in_ch[3] and in_ch[0] rise in the same cycle -> miss=1, hit=0.
REQ-038 timeout_cyc=10, no press -> timed_out=1 and done pulses exactly 10 cycles after WAIT_HIT entry; timeout_cyc=0 -> no timeout after 1000 cycles.
REQ-039 in_ch[1] held high at start -> FSM stays in ARM; release, then press in_ch[1] -> counted as a new edge.
REQ-040 N_CH=5, 1000 rounds -> target always < 5; rst mid-WAIT_HIT -> all outputs 0, no done, target=0.
